// File: rtl/ring_scan_display.sv
// Multiplexed seven-segment scan driver that follows a one-hot ring-counter phase.
// Optional phase-integrity checking is enabled with RING_SCAN_ONEHOT_CHECK_EN.
module ring_scan_display #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   phase_i,
    input  logic           val_valid_i,
    output logic           val_ready_o,
    input  logic [4*N-1:0] val_data_i,
    input  logic [N-1:0]   val_dp_i,
    output logic [N-1:0]   an_o,
    output logic [6:0]     seg_o,
    output logic           dp_o,
    output logic           frame_done_o,
    output logic           err_o
);
    localparam logic [N-1:0] TOP = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    logic [4*N-1:0] pend_data_q, disp_q, disp_d;
    logic [N-1:0]   pend_dp_q, disp_dp_q, disp_dp_d;
    logic           pend_full_q, pend_full_d;
    logic           disp_valid_q, disp_valid_d;
    logic           prev_top_q;
    logic [N-1:0]   an_q, an_d;
    logic [6:0]     seg_q, seg_d;
    logic           dp_q, dp_d;
    logic           frame_done_q;
    logic           accept, fs, onehot;
    logic [3:0]     nib;
    logic           dp_sel;

    assign val_ready_o = ~pend_full_q;
    assign accept      = val_valid_i & ~pend_full_q;
    assign onehot      = (phase_i != '0) && ((phase_i & (phase_i - ONE)) == '0);
    // prev_top_q is cleared by reset, so a TOP phase right after reset starts a frame
    assign fs          = (phase_i == TOP) && !prev_top_q;

    always_comb begin
        disp_d       = disp_q;
        disp_dp_d    = disp_dp_q;
        disp_valid_d = disp_valid_q;
        pend_full_d  = pend_full_q;
        if (accept) begin
            pend_full_d = 1'b1;
        end else if (fs && pend_full_q) begin
            disp_d       = pend_data_q;
            disp_dp_d    = pend_dp_q;
            disp_valid_d = 1'b1;
            pend_full_d  = 1'b0;
        end
    end

    // Digit shown at a frame start uses the value adopted on that same cycle
    always_comb begin
        nib    = 4'h0;
        dp_sel = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (phase_i[i]) begin
                nib    = disp_d[4*i +: 4];
                dp_sel = disp_dp_d[i];
            end
        end
        an_d  = '1;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        if (onehot && disp_valid_d) begin
            an_d  = ~phase_i;
            seg_d = hex7(nib);
            dp_d  = ~dp_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_data_q  <= '0;
            pend_dp_q    <= '0;
            pend_full_q  <= 1'b0;
            disp_q       <= '0;
            disp_dp_q    <= '0;
            disp_valid_q <= 1'b0;
            prev_top_q   <= 1'b0;
            an_q         <= '1;
            seg_q        <= 7'h7F;
            dp_q         <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            if (accept) begin
                pend_data_q <= val_data_i;
                pend_dp_q   <= val_dp_i;
            end
            pend_full_q  <= pend_full_d;
            disp_q       <= disp_d;
            disp_dp_q    <= disp_dp_d;
            disp_valid_q <= disp_valid_d;
            prev_top_q   <= (phase_i == TOP);
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_done_q <= fs;
        end
    end

    assign an_o         = an_q;
    assign seg_o        = seg_q;
    assign dp_o         = dp_q;
    assign frame_done_o = frame_done_q;

`ifdef RING_SCAN_ONEHOT_CHECK_EN
    logic [N-1:0] prev_phase_q;
    logic         prev_valid_q;
    logic         err_q, err_d;
    logic [N-1:0] rot_prev;

    assign rot_prev = {prev_phase_q[0], prev_phase_q[N-1:1]};
    // The first sample after reset has no predecessor to compare against
    assign err_d    = err_q | ~onehot | (prev_valid_q && (phase_i != rot_prev));

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_phase_q <= '0;
            prev_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            prev_phase_q <= phase_i;
            prev_valid_q <= 1'b1;
            err_q        <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: doc/ring_scan_display.md
# ring_scan_display

Multiplexed seven-segment scan driver that consumes the one-hot phase produced by the 4-bit ring counter. The ring counter resets to 1000 and rotates right. Each phase bit selects one digit: its anode is driven and its hex nibble is decoded onto shared segment lines. A display value is loaded through a valid/ready handshake and adopted only at frame boundaries, so a frame never shows a mix of old and new digits.

## Interface
- N, 4: digits and phase width; val_data is 4*N bits.
- clk  in  1  rising-edge clock, shared with the ring counter.
- rst  in  1  reset: synchronous, active-high.
- phase  in  N  one-hot digit select from the ring counter. Bit N-1 is the first digit of a frame.
- val_valid  in  1  new display value offered.
- val_ready  out  1  combinational; high when the pending buffer is empty.
- val_data  in  4N  hex nibbles; nibble i (bits 4i+3:4i) is shown when phase[i]=1.
- val_dp  in  N  decimal point per digit, active-high.
- an  out  N  anodes, active-low, registered.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low, registered.
- dp  out  1  decimal point, active-low, registered.
- frame_done  out  1  one-cycle pulse per frame start.
- err  out  1  sticky phase-integrity error.

## Operation
- Storage:
  - pending buffer: 4N+N bits plus pend_full.
  - display register: disp plus disp_valid.
- Handshake:
  - Accept when val_valid && val_ready; write the pending buffer and set pend_full=1.
  - val_data/val_dp are sampled only on the accept cycle.
  - A valid held while ready=0 waits; nothing is dropped.
- Frame start (fs) is true when phase == 1<<(N-1) and the previous phase sample was not 1<<(N-1).
  - Also true on the first sample after reset when phase == 1<<(N-1).
- On fs with pend_full=1:
  - Copy pending into disp, set disp_valid=1, clear pend_full.
  - The value adopted at fs is used for the digit shown at fs.
- Simultaneous accept and fs are impossible with pend_full=1, because ready=0.
  - With pend_full=0, accept fills pending; it is adopted at the next fs, not the current one.
- Digit output, registered from the current phase:
  - Legal one-hot phase with disp_valid=1: an=~phase, seg=hex7(disp nibble i), dp=~val_dp_disp[i].
  - disp_valid=0 or non-one-hot phase (including 0): an=all ones, seg=7'h7F, dp=1.
- hex7 (active-low, g..a):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000.
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- frame_done: registered copy of fs.

## Timing
- Reset values:
  - an=all ones, seg=7'h7F, dp=1, frame_done=0, err=0.
  - pend_full=0 (so val_ready=1), disp_valid=0, disp=0.
  - Previous-phase-valid flag cleared.
- Latency:
  - phase to an/seg/dp: 1 cycle.
  - fs to frame_done: 1 cycle, coincident with the first digit's output.
  - Accept to val_ready low: next cycle.
  - Adopt at the first fs after the accept cycle; val_ready returns high the cycle after that fs.
- Reset mid-operation:
  - Pending and displayed values are discarded, err is cleared, outputs blank from the cycle after rst is sampled.
  - No value shows until a new load and fs.
- Wrap-around: phase 0001 -> 1000 is a normal frame boundary.

## Configuration
- Macro RING_SCAN_ONEHOT_CHECK_EN, when defined:
  - err sets and stays set until rst when either condition holds:
    - phase is not exactly one-hot;
    - phase differs from the right-rotation of the previous sample. The first sample after reset is exempt from this check.
  - err registers 1 cycle after the offending sample.
- When undefined:
  - err is a constant 0 and no previous-phase comparison logic exists.
  - Blanking on a non-one-hot phase still applies.

## Test plan
- Reset: rst=1 for 2 cycles, phase=1000 -> an=1111, seg=1111111, dp=1, err=0, frame_done=0, val_ready=1.
- Load and scan:
  - Stimulus: accept 16'h1234 with val_dp=0001 while phase=0010; ring continues to 0001, 1000, ...
  - Response: frame_done pulses with an=0111/seg=1111001; then an=1011/0100100, an=1101/0110000, an=1110/0011001 with dp=0.
- Backpressure:
  - Stimulus: accept 16'hABCD; hold val_valid with 16'h00EF.
  - Response: val_ready=0 until the cycle after the next fs; 16'h00EF is adopted at the following fs; no digit of a frame mixes values.
- Illegal phase (macro on): inject phase=0110 for 1 cycle -> an=1111 next cycle; err=1 and stays 1 after phase recovers.
- Skipped phase (macro on): sequence 1000 -> 0010 -> err=1. With the macro off, the same stimulus gives err=0, and the 0110 case still blanks.
- Reset mid-frame: pend_full=1 and digit 2 active, assert rst for 1 cycle -> val_ready=1, outputs blank, err=0; nothing shows until the next load and fs.
